// File: rtl/seven_seg_scan_capture.sv
// seven_seg_scan_capture: readback receiver for a multiplexed 4-digit
// seven-segment display bus. It samples one scan position per clk_17 edge,
// decodes the active-low segments to BCD and reassembles a frame. A frame is
// published only after it has repeated unchanged STABLE_FRAMES times.
//
// Ports:
//   clk_17      scan clock; one display position is sampled per rising edge
//   rst         asynchronous, active-high reset
//   an[3:0]     anode enables, active-low one-hot (0111 = position 3)
//   seg[6:0]    segments, active-low, seg[6]=a .. seg[0]=g
//   dp          decimal point, active-low
//   d3..d0      published BCD digits
//   dot_mask    published dots, bit i set = dot lit on position i
//   frame_valid one-cycle pulse when the published outputs are updated
//   locked      scan order intact and at least one frame published
//   seg_err     one-cycle pulse on an undecodable segment pattern
//   scan_err    one-cycle pulse on an illegal or out-of-order anode pattern
module seven_seg_scan_capture #(
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic       clk_17,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  input  logic       dp,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [3:0] dot_mask,
  output logic       frame_valid,
  output logic       locked,
  output logic       seg_err,
  output logic       scan_err
);

  localparam int unsigned DIG_W   = 4;
  localparam int unsigned NUM_POS = 4;
  localparam int unsigned FRAME_W = DIG_W * NUM_POS;
  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = 4'd15;
  localparam logic [CNT_W-1:0] STABLE_Q = CNT_W'(STABLE_FRAMES);
  localparam logic [3:0] AN_POS3 = 4'b0111;

  typedef enum logic {HUNT, CAPTURE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           exp_pos, exp_pos_nxt;
  logic [FRAME_W-1:0]   cap_dig, cap_dig_nxt;
  logic [NUM_POS-1:0]   cap_dot, cap_dot_nxt;
  logic [FRAME_W-1:0]   prev_dig, prev_dig_nxt;
  logic [NUM_POS-1:0]   prev_dot, prev_dot_nxt;
  logic [CNT_W-1:0]     stable_cnt, stable_cnt_nxt;
  logic                 frame_bad, frame_bad_nxt;
  logic [FRAME_W-1:0]   out_dig, out_dig_nxt;
  logic [NUM_POS-1:0]   out_dot, out_dot_nxt;
  logic                 frame_valid_nxt, locked_nxt, seg_err_nxt, scan_err_nxt;

  logic [DIG_W-1:0]     dec_dig;
  logic                 dec_ok;
  logic [3:0]           exp_an;
  logic [FRAME_W-1:0]   new_dig;
  logic [NUM_POS-1:0]   new_dot;
  logic                 bad_now;

  // Active-low segment pattern to BCD.
  always_comb begin
    dec_ok  = 1'b1;
    dec_dig = 4'd0;
    case (seg)
      7'b0000001: dec_dig = 4'd0;
      7'b1001111: dec_dig = 4'd1;
      7'b0010010: dec_dig = 4'd2;
      7'b0000110: dec_dig = 4'd3;
      7'b1001100: dec_dig = 4'd4;
      7'b0100100: dec_dig = 4'd5;
      7'b0100000: dec_dig = 4'd6;
      7'b0001111: dec_dig = 4'd7;
      7'b0000000: dec_dig = 4'd8;
      7'b0000100: dec_dig = 4'd9;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // Frame contents including the sample at the expected position.
  always_comb begin
    exp_an  = 4'b1111 ^ (4'b0001 << exp_pos);
    new_dig = cap_dig;
    new_dot = cap_dot;
    new_dig[{exp_pos, 2'b00} +: DIG_W] = dec_dig;
    new_dot[exp_pos] = ~dp;
    bad_now = frame_bad | ~dec_ok;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt       = state;
    exp_pos_nxt     = exp_pos;
    cap_dig_nxt     = cap_dig;
    cap_dot_nxt     = cap_dot;
    prev_dig_nxt    = prev_dig;
    prev_dot_nxt    = prev_dot;
    stable_cnt_nxt  = stable_cnt;
    frame_bad_nxt   = frame_bad;
    out_dig_nxt     = out_dig;
    out_dot_nxt     = out_dot;
    frame_valid_nxt = 1'b0;
    locked_nxt      = locked;
    seg_err_nxt     = 1'b0;
    scan_err_nxt    = 1'b0;

    case (state)
      HUNT: begin
        // Errors are silent here, but a bad digit still spoils the frame.
        if (an == AN_POS3) begin
          state_nxt               = CAPTURE;
          exp_pos_nxt             = 2'd2;
          cap_dig_nxt[15:12]      = dec_dig;
          cap_dot_nxt[3]          = ~dp;
          frame_bad_nxt           = ~dec_ok;
        end
      end
      CAPTURE: begin
        if (an != exp_an) begin
          // scan_err outranks seg_err on the same sample.
          scan_err_nxt   = 1'b1;
          locked_nxt     = 1'b0;
          stable_cnt_nxt = '0;
          frame_bad_nxt  = 1'b0;
          state_nxt      = HUNT;
        end else begin
          cap_dig_nxt = new_dig;
          cap_dot_nxt = new_dot;
          seg_err_nxt = ~dec_ok;
          exp_pos_nxt = 2'(exp_pos - 2'd1);
          if (exp_pos == 2'd0) begin
            frame_bad_nxt = 1'b0;
            if (bad_now) begin
              stable_cnt_nxt = '0;
            end else begin
              // From a cleared count an equal frame also lands on 1.
              if (new_dig == prev_dig && new_dot == prev_dot)
                stable_cnt_nxt = (stable_cnt == CNT_MAX) ? CNT_MAX
                                                         : CNT_W'(stable_cnt + 4'd1);
              else
                stable_cnt_nxt = 4'd1;
              prev_dig_nxt = new_dig;
              prev_dot_nxt = new_dot;
              if (stable_cnt_nxt >= STABLE_Q) begin
                out_dig_nxt     = new_dig;
                out_dot_nxt     = new_dot;
                frame_valid_nxt = 1'b1;
                locked_nxt      = 1'b1;
              end
            end
          end else begin
            frame_bad_nxt = bad_now;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_17 or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      exp_pos     <= 2'd3;
      cap_dig     <= '0;
      cap_dot     <= '0;
      prev_dig    <= '0;
      prev_dot    <= '0;
      stable_cnt  <= '0;
      frame_bad   <= 1'b0;
      out_dig     <= '0;
      out_dot     <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      seg_err     <= 1'b0;
      scan_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      exp_pos     <= exp_pos_nxt;
      cap_dig     <= cap_dig_nxt;
      cap_dot     <= cap_dot_nxt;
      prev_dig    <= prev_dig_nxt;
      prev_dot    <= prev_dot_nxt;
      stable_cnt  <= stable_cnt_nxt;
      frame_bad   <= frame_bad_nxt;
      out_dig     <= out_dig_nxt;
      out_dot     <= out_dot_nxt;
      frame_valid <= frame_valid_nxt;
      locked      <= locked_nxt;
      seg_err     <= seg_err_nxt;
      scan_err    <= scan_err_nxt;
    end
  end

  assign d3       = out_dig[15:12];
  assign d2       = out_dig[11:8];
  assign d1       = out_dig[7:4];
  assign d0       = out_dig[3:0];
  assign dot_mask = out_dot;

endmodule
